sdio3w_cfg_ctrl: RTL
====================

Name: sdio3w_cfg_ctrl

Overview:
- 3-wire SPI master for ADC/PLL configuration registers.
- The bidirectional SDIO line goes through a single-ended PF_IO bidirectional pad instance.
- The block drives the pad's D and E inputs and samples its Y output.
- It sequences one register transaction at a time: 24-bit frame = R/W bit, 15-bit address, 8-bit data, with a bus turnaround for reads.
- Sits between the command decoder (register request/response) and the pad plus SCLK/CS_N outputs.

Parameters:
- CLK_DIV, 4: CLK cycles per SCLK half-period. Legal values 3..255; the compile-time check must fail for values below 3.
- ADDR_W, 15: register address width.
- DATA_W, 8: register data width. Frame length FRAME_W = 1 + ADDR_W + DATA_W = 24.

Ports:
- CLK  in  1  system clock; the only clock.
- RESET  in  1  synchronous, active-high reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  block can accept a request.
- REQ_RW  in  1  1 = read, 0 = write.
- REQ_ADDR  in  ADDR_W  register address.
- REQ_WDATA  in  DATA_W  write data; ignored for reads.
- RSP_VALID  out  1  one-cycle pulse when a transaction completes.
- RSP_RDATA  out  DATA_W  read data; 0 after a write.
- BUSY  out  1  high from the accept edge until return to IDLE.
- SPI_CS_N  out  1  chip select, active low.
- SPI_SCLK  out  1  serial clock, idle low.
- SDIO_D  out  1  to pad D.
- SDIO_E  out  1  to pad E (1 = drive).
- SDIO_Y  in  1  from pad Y; asynchronous, passes through a 2-FF synchroniser inside the block.

Behaviour:
- Reset values (all outputs registered): REQ_READY=0 during reset, 1 in IDLE; RSP_VALID=0; RSP_RDATA=0; BUSY=0; SPI_CS_N=1; SPI_SCLK=0; SDIO_D=0; SDIO_E=0; state=IDLE; synchroniser flops=0.
- Handshake and latch:
  - Accept when REQ_VALID & REQ_READY at a rising edge.
  - On accept, latch {REQ_RW, REQ_ADDR, REQ_WDATA} into shift register SR[23:0], MSB first.
  - REQ_READY falls in the cycle after accept; REQ_VALID is ignored while REQ_READY=0.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> DONE -> GAP -> IDLE.
- SETUP (CLK_DIV cycles):
  - CS_N=0, SCLK=0, SDIO_E=1, SDIO_D=SR[23], BUSY=1.
- SHIFT: FRAME_W bits, each 2*CLK_DIV cycles.
  - Low half: SCLK=0; SDIO_D is updated to the current bit on the first cycle of the low half.
  - High half: SCLK=1; the device samples on the rising edge.
  - Bit counter counts 0..23.
- Read turnaround:
  - When REQ_RW=1, SDIO_E falls on the first cycle of bit 16's low half, aligned with that SCLK falling edge; SDIO_D=0 from then on.
  - For read bits 16..23, the synchronised SDIO_Y is sampled on the last cycle of each high half and shifted into RDATA LSB-first-in (MSB received first).
  - Writes keep SDIO_E=1 for all 24 bits.
- HOLD (CLK_DIV cycles): SCLK=0, CS_N=0, SDIO_E=0.
- DONE (1 cycle):
  - CS_N=1, RSP_VALID=1, RSP_RDATA = captured byte (read) or 0 (write).
  - RSP_RDATA holds its value until the next DONE or reset.
- GAP (CLK_DIV cycles): CS_N=1. At the end, go to IDLE with REQ_READY=1 and BUSY=0.
- Latency:
  - RSP_VALID is asserted in cycle 50*CLK_DIV+1 after the accept edge (201 for CLK_DIV=4).
  - The next accept is possible no earlier than cycle 51*CLK_DIV+2 after the previous accept.
- Boundary cases:
  - RESET asserted mid-transaction: the next edge forces all reset values (CS_N=1, SDIO_E=0 immediately). No RSP_VALID is produced and the latched request is discarded.
  - REQ_VALID and RESET high together: reset wins and nothing is accepted.
  - Never drive SDIO_E=1 while SPI_CS_N=1.
  - SCLK toggles only while CS_N=0.
  - Exactly 24 rising SCLK edges per frame.

Test Plan:
- Write, CLK_DIV=4, ADDR=0x0015, WDATA=0xA5 -> SDIO_D frame 0x0015A5 MSB first; 24 SCLK rising edges; SDIO_E=1 throughout CS_N low (except HOLD); RSP_VALID exactly at cycle 201; RSP_RDATA=0.
- Read, ADDR=0x0001, device model drives 0x3C on SCLK falling edges from bit 16 -> first 16 bits are 0x8001; SDIO_E falls with the SCLK fall of bit 16; RSP_RDATA=0x3C; RSP_VALID for 1 cycle.
- Back-to-back: REQ_VALID held high with two queued requests (write then read) -> the second is accepted exactly at cycle 51*CLK_DIV+2 after the first; CS_N high for ≥CLK_DIV cycles between frames; REQ_READY=0 throughout the first transaction.
- RESET pulsed during bit 10 of a write -> next cycle CS_N=1, SCLK=0, SDIO_E=0, BUSY=0; no RSP_VALID; a following read completes correctly.
- CLK_DIV=3 read of 0xFF, then of 0x00 -> correct capture despite the 2-cycle synchroniser latency; RSP_VALID at cycle 151.
- Assertion checker across all tests -> SDIO_E implies !SPI_CS_N; SCLK stays 0 whenever CS_N=1; RSP_VALID never lasts 2 consecutive cycles.

Source files
------------

// File: rtl/sdio3w_cfg_ctrl.sv
// 3-wire SPI master: sequences one R/W + address + data register frame over a
// bidirectional SDIO pad (D/E out, Y in) with bus turnaround for reads.
module sdio3w_cfg_ctrl #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned ADDR_W  = 15,
  parameter int unsigned DATA_W  = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_RW,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_WDATA,
  output logic              RSP_VALID,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              BUSY,
  output logic              SPI_CS_N,
  output logic              SPI_SCLK,
  output logic              SDIO_D,
  output logic              SDIO_E,
  input  logic              SDIO_Y
);

  localparam int unsigned FRAME_W  = 1 + ADDR_W + DATA_W;
  localparam int unsigned CNT_W    = $clog2(2 * CLK_DIV);
  localparam int unsigned BIT_W    = $clog2(FRAME_W);
  localparam int unsigned RD_START = 1 + ADDR_W;

  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HIGH_FIRST = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] RD_FIRST   = BIT_W'(RD_START);

  if (CLK_DIV < 3 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("CLK_DIV must be within 3..255");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_DONE,
    ST_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [FRAME_W-1:0]  sr_q, sr_d;
  logic                rw_q, rw_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          sync_q;

  logic                turn_c;
  logic                cs_n_c, sclk_c, sdio_d_c, sdio_e_c, rsp_valid_c;
  logic [DATA_W-1:0]   rsp_rdata_c;

  // Next-state, datapath and pin decode; pins are registered one cycle later.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    sr_d        = sr_q;
    rw_d        = rw_q;
    rdata_d     = rdata_q;
    turn_c      = 1'b0;
    cs_n_c      = 1'b1;
    sclk_c      = 1'b0;
    sdio_d_c    = 1'b0;
    sdio_e_c    = 1'b0;
    rsp_valid_c = 1'b0;
    rsp_rdata_c = RSP_RDATA;

    case (state_q)
      ST_IDLE: begin
        if (REQ_VALID && REQ_READY) begin
          state_d = ST_SETUP;
          cnt_d   = '0;
          sr_d    = {REQ_RW, REQ_ADDR, REQ_WDATA};
          rw_d    = REQ_RW;
          rdata_d = '0;
        end
      end
      ST_SETUP: begin
        cs_n_c   = 1'b0;
        sdio_e_c = 1'b1;
        sdio_d_c = sr_q[FRAME_W-1];
        if (cnt_q == HALF_LAST) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        // Reads release the line for the data byte so the device can drive it.
        turn_c   = rw_q && (bit_q >= RD_FIRST);
        cs_n_c   = 1'b0;
        sclk_c   = (cnt_q >= HIGH_FIRST);
        sdio_e_c = !turn_c;
        sdio_d_c = turn_c ? 1'b0 : sr_q[FRAME_W-1];
        if (cnt_q == BIT_LAST) begin
          if (turn_c) begin
            rdata_d = {rdata_q[DATA_W-2:0], sync_q[1]};
          end
          cnt_d = '0;
          sr_d  = {sr_q[FRAME_W-2:0], 1'b0};
          if (bit_q == LAST_BIT) begin
            state_d = ST_HOLD;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        cs_n_c = 1'b0;
        if (cnt_q == HALF_LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        rsp_valid_c = 1'b1;
        rsp_rdata_c = rw_q ? rdata_q : '0;
        state_d     = ST_GAP;
        cnt_d       = '0;
      end
      ST_GAP: begin
        if (cnt_q == HALF_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath, synchroniser and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sr_q      <= '0;
      rw_q      <= 1'b0;
      rdata_q   <= '0;
      sync_q    <= '0;
      REQ_READY <= 1'b0;
      BUSY      <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_RDATA <= '0;
      SPI_CS_N  <= 1'b1;
      SPI_SCLK  <= 1'b0;
      SDIO_D    <= 1'b0;
      SDIO_E    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sr_q      <= sr_d;
      rw_q      <= rw_d;
      rdata_q   <= rdata_d;
      sync_q    <= {sync_q[0], SDIO_Y};
      REQ_READY <= (state_d == ST_IDLE);
      BUSY      <= (state_d != ST_IDLE);
      RSP_VALID <= rsp_valid_c;
      RSP_RDATA <= rsp_rdata_c;
      SPI_CS_N  <= cs_n_c;
      SPI_SCLK  <= sclk_c;
      SDIO_D    <= sdio_d_c;
      SDIO_E    <= sdio_e_c;
    end
  end

endmodule
